// File: rtl/beep_pkg.sv
// Shared types and helpers for the buzzer beep scheduler.
package beep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF,
    ST_DONE
  } beep_state_e;

  localparam int TONE_W = 5;
  localparam logic [TONE_W-1:0] TONE_RST = 5'h08;

  // Widest request vector the select helper accepts
  localparam int MAX_REQ = 32;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } sel_t;

  function automatic sel_t lowest_set(input logic [MAX_REQ-1:0] vec);
    sel_t s;
    s = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        s.valid = 1'b1;
        s.idx   = 5'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/beep_tick_gen.sv
// Pattern tick prescaler: counts 0..TICK_DIV-1, pulses tick on the last count,
// and restarts from 0 whenever clr is asserted.
module beep_tick_gen #(
  parameter int TICK_DIV = 32
) (
  input  logic i_clk_32k,
  input  logic i_Rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge i_clk_32k) begin
    if (i_Rst || clr)       presc <= '0;
    else if (presc == LAST) presc <= '0;
    else                    presc <= presc + 1'b1;
  end

  assign tick = (presc == LAST);

endmodule

// File: rtl/beep_sched.sv
// Fixed-priority buzzer sequencer: owner plays ON/OFF bursts of its latched pattern.
// Optional BEEP_SCHED_MUTE_EN adds i_mute, which silences o_BeepEnable only.
module beep_sched
  import beep_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 32,
  parameter int CNT_W    = 8,
  parameter int REP_W    = 4
) (
  input  logic                      i_clk_32k,
  input  logic                      i_Rst,
`ifdef BEEP_SCHED_MUTE_EN
  input  logic                      i_mute,
`endif
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [TONE_W*NUM_REQ-1:0] i_tone,
  input  logic [CNT_W*NUM_REQ-1:0]  i_on_ticks,
  input  logic [CNT_W*NUM_REQ-1:0]  i_off_ticks,
  input  logic [REP_W*NUM_REQ-1:0]  i_repeat,
  output logic                      o_BeepEnable,
  output logic [TONE_W-1:0]         o_divide,
  output logic                      o_busy,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  beep_state_e         state_q, state_d;
  logic [IDX_W-1:0]    owner_q, win_idx;
  logic [TONE_W-1:0]   tone_q;
  logic [CNT_W-1:0]    on_q, off_q, phase_q, phase_len;
  logic [REP_W-1:0]    rep_q, burst_q, burst_inc;
  logic [NUM_REQ-1:0]  lockout_q, owner_oh, eligible;
  logic                tick, enter, load, phase_end, preempt;
  sel_t                win;

  assign eligible  = i_req & ~lockout_q;
  assign win       = lowest_set(MAX_REQ'(eligible));
  assign win_idx   = IDX_W'(win.idx);
  assign preempt   = win.valid && (win.idx < 5'(owner_q));
  assign owner_oh  = NUM_REQ'(1) << owner_q;
  assign burst_inc = (&burst_q) ? burst_q : burst_q + 1'b1;
  assign phase_len = (state_q == ST_ON) ? ((on_q == '0) ? CNT_W'(1) : on_q) : off_q;
  assign phase_end = tick && (phase_q == phase_len - 1'b1);

  beep_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk_32k (i_clk_32k),
    .i_Rst     (i_Rst),
    .clr       (enter),
    .tick      (tick)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge i_clk_32k) begin
    if (i_Rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a latch.
    state_d = state_q;
    load    = 1'b0;
    enter   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win.valid) begin
          load    = 1'b1;
          enter   = 1'b1;
          state_d = ST_ON;
        end
      end
      default: begin
        if (preempt) begin
          load    = 1'b1;
          enter   = 1'b1;
          state_d = ST_ON;
        end else if (state_q == ST_DONE || !i_req[owner_q]) begin
          enter   = 1'b1;
          state_d = ST_IDLE;
        end else if (phase_end) begin
          enter = 1'b1;
          // A zero OFF length skips OFF entirely; bursts are counted at ON end
          if (state_q == ST_ON && off_q != '0)
            state_d = ST_OFF;
          else if (rep_q != '0 && ((state_q == ST_ON) ? burst_inc : burst_q) >= rep_q)
            state_d = ST_DONE;
          else
            state_d = ST_ON;
        end
      end
    endcase
  end

  // NOTE: pattern registers are cleared on reset too, so no X can leak out
  // through o_divide or the phase compare after a mid-pattern reset.
  always_ff @(posedge i_clk_32k) begin
    if (i_Rst) begin
      owner_q   <= '0;
      tone_q    <= '0;
      on_q      <= '0;
      off_q     <= '0;
      rep_q     <= '0;
      burst_q   <= '0;
      phase_q   <= '0;
      lockout_q <= '0;
    end else begin
      lockout_q <= (lockout_q & i_req) | ((state_q == ST_DONE) ? owner_oh : '0);
      if (load) begin
        owner_q <= win_idx;
        tone_q  <= i_tone[win_idx*TONE_W +: TONE_W];
        on_q    <= i_on_ticks[win_idx*CNT_W +: CNT_W];
        off_q   <= i_off_ticks[win_idx*CNT_W +: CNT_W];
        rep_q   <= i_repeat[win_idx*REP_W +: REP_W];
        burst_q <= '0;
      end else if (state_q == ST_ON && phase_end) begin
        burst_q <= burst_inc;
      end
      if (enter)     phase_q <= '0;
      else if (tick) phase_q <= phase_q + 1'b1;
    end
  end

  always_comb begin
    o_busy       = (state_q != ST_IDLE);
    o_grant      = o_busy ? owner_oh : '0;
    o_done       = (state_q == ST_DONE) ? owner_oh : '0;
    o_divide     = o_busy ? tone_q : TONE_RST;
`ifdef BEEP_SCHED_MUTE_EN
    o_BeepEnable = (state_q == ST_ON) && !i_mute;
`else
    o_BeepEnable = (state_q == ST_ON);
`endif
  end

endmodule

// File: tb/tb_beep_sched.sv
// Directed self-checking bench for beep_sched with TICK_DIV=4.
module tb_beep_sched;

  logic        clk = 1'b0;
  logic        rst;
`ifdef BEEP_SCHED_MUTE_EN
  logic        mute;
`endif
  logic [3:0]  req;
  logic [19:0] tone;
  logic [31:0] on_t, off_t;
  logic [15:0] rep;
  logic        en;
  logic [4:0]  divide;
  logic        busy;
  logic [3:0]  grant, done;

  int n_tests = 0;
  int n_fail  = 0;

  beep_sched #(.NUM_REQ(4), .TICK_DIV(4), .CNT_W(8), .REP_W(4)) dut (
    .i_clk_32k    (clk),
    .i_Rst        (rst),
`ifdef BEEP_SCHED_MUTE_EN
    .i_mute       (mute),
`endif
    .i_req        (req),
    .i_tone       (tone),
    .i_on_ticks   (on_t),
    .i_off_ticks  (off_t),
    .i_repeat     (rep),
    .o_BeepEnable (en),
    .o_divide     (divide),
    .o_busy       (busy),
    .o_grant      (grant),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_en, input logic [3:0] e_grant,
                            input logic e_busy, input logic [3:0] e_done, input logic [4:0] e_div);
    check({tag, ".en"},     32'(en),     32'(e_en));
    check({tag, ".grant"},  32'(grant),  32'(e_grant));
    check({tag, ".busy"},   32'(busy),   32'(e_busy));
    check({tag, ".done"},   32'(done),   32'(e_done));
    check({tag, ".divide"}, 32'(divide), 32'(e_div));
  endtask

  task automatic set_pat(input int idx, input logic [4:0] t, input logic [7:0] on,
                         input logic [7:0] off, input logic [3:0] r);
    tone[idx*5 +: 5]  = t;
    on_t[idx*8 +: 8]  = on;
    off_t[idx*8 +: 8] = off;
    rep[idx*4 +: 4]   = r;
  endtask

  initial begin
    rst = 1'b1; req = '0; tone = '0; on_t = '0; off_t = '0; rep = '0;
`ifdef BEEP_SCHED_MUTE_EN
    mute = 1'b0;
`endif
    tick(2);
    check_outs("reset", 1'b0, 4'b0000, 1'b0, 4'b0000, 5'h08);
    rst = 1'b0;
    tick();
    check_outs("idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 5'h08);

    // Single burst: 8 cycles ON, 12 OFF, then done pulse
    set_pat(0, 5'b00100, 8'd2, 8'd3, 4'd1);
    req[0] = 1'b1;
    tick();
    check_outs("b1_on_first", 1'b1, 4'b0001, 1'b1, 4'b0000, 5'b00100);
    tick(7);
    check_outs("b1_on_last", 1'b1, 4'b0001, 1'b1, 4'b0000, 5'b00100);
    tick();
    check_outs("b1_off_first", 1'b0, 4'b0001, 1'b1, 4'b0000, 5'b00100);
    tick(11);
    check_outs("b1_off_last", 1'b0, 4'b0001, 1'b1, 4'b0000, 5'b00100);
    tick();
    check_outs("b1_done", 1'b0, 4'b0001, 1'b1, 4'b0001, 5'b00100);
    tick();
    check_outs("b1_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 5'h08);

    // Lockout: held request is not regranted until dropped
    tick(3);
    check_outs("lock_held", 1'b0, 4'b0000, 1'b0, 4'b0000, 5'h08);
    req[0] = 1'b0;
    tick();
    req[0] = 1'b1;
    tick();
    check_outs("lock_regrant", 1'b1, 4'b0001, 1'b1, 4'b0000, 5'b00100);
    req[0] = 1'b0;
    tick();
    check_outs("drop0", 1'b0, 4'b0000, 1'b0, 4'b0000, 5'h08);

    // Preemption of a continuous pattern by a higher-priority source
    set_pat(2, 5'b00010, 8'd5, 8'd1, 4'd0);
    req[2] = 1'b1;
    tick();
    check_outs("pre_own2", 1'b1, 4'b0100, 1'b1, 4'b0000, 5'b00010);
    tick(3);
    set_pat(1, 5'b01000, 8'd2, 8'd2, 4'd1);
    req[1] = 1'b1;
    tick();
    check_outs("pre_own1", 1'b1, 4'b0010, 1'b1, 4'b0000, 5'b01000);
    tick(7);
    check_outs("pre_on_last", 1'b1, 4'b0010, 1'b1, 4'b0000, 5'b01000);
    tick();
    check_outs("pre_off", 1'b0, 4'b0010, 1'b1, 4'b0000, 5'b01000);
    req[1] = 1'b0;
    req[2] = 1'b0;
    tick();
    check_outs("pre_drop", 1'b0, 4'b0000, 1'b0, 4'b0000, 5'h08);

    // Owner drop during OFF
    set_pat(3, 5'b10000, 8'd1, 8'd4, 4'd2);
    req[3] = 1'b1;
    tick();
    check_outs("od_on", 1'b1, 4'b1000, 1'b1, 4'b0000, 5'b10000);
    tick(4);
    check_outs("od_off", 1'b0, 4'b1000, 1'b1, 4'b0000, 5'b10000);
    tick(2);
    req[3] = 1'b0;
    tick();
    check_outs("od_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 5'h08);
    tick();
    check("od_no_done", 32'(done), 32'd0);

    // off=0: three 4-cycle bursts merge into 12 continuous ON cycles
    set_pat(0, 5'b00001, 8'd1, 8'd0, 4'd3);
    req[0] = 1'b1;
    tick();
    check_outs("z_on", 1'b1, 4'b0001, 1'b1, 4'b0000, 5'b00001);
    for (int i = 2; i <= 12; i++) begin
      tick();
      check("z_en_cont", 32'(en), 32'd1);
    end
    tick();
    check_outs("z_done", 1'b0, 4'b0001, 1'b1, 4'b0001, 5'b00001);
    tick();
    check_outs("z_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 5'h08);
    req[0] = 1'b0;
    tick();

    // on=0 behaves as on=1
    set_pat(0, 5'b00100, 8'd0, 8'd1, 4'd1);
    req[0] = 1'b1;
    tick();
    check("on0_first", 32'(en), 32'd1);
    tick(3);
    check("on0_last", 32'(en), 32'd1);
    tick();
    check_outs("on0_off", 1'b0, 4'b0001, 1'b1, 4'b0000, 5'b00100);
    tick(3);
    check("on0_off_nodone", 32'(done), 32'd0);
    tick();
    check("on0_done", 32'(done), 32'b0001);
    req[0] = 1'b0;
    tick(2);
    check_outs("on0_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 5'h08);

    // Reset mid-pattern clears state and lockout
    set_pat(1, 5'b01000, 8'd1, 8'd1, 4'd1);
    set_pat(2, 5'b00010, 8'd3, 8'd1, 4'd0);
    req[1] = 1'b1;
    req[2] = 1'b1;
    tick();
    check("rst_own1", 32'(grant), 32'b0010);
    tick(8);
    check("rst_done1", 32'(done), 32'b0010);
    tick();
    check("rst_idle", 32'(busy), 32'd0);
    tick();
    check_outs("rst_own2", 1'b1, 4'b0100, 1'b1, 4'b0000, 5'b00010);
    tick(2);
    rst = 1'b1;
    tick();
    check_outs("rst_mid", 1'b0, 4'b0000, 1'b0, 4'b0000, 5'h08);
    rst = 1'b0;
    tick();
    check_outs("rst_lock_clear", 1'b1, 4'b0010, 1'b1, 4'b0000, 5'b01000);

`ifdef BEEP_SCHED_MUTE_EN
    mute = 1'b1;
    #1;
    check_outs("mute_on", 1'b0, 4'b0010, 1'b1, 4'b0000, 5'b01000);
    mute = 1'b0;
    #1;
    check("mute_off", 32'(en), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
